// File: rtl/ccip_avmm_pkg.sv
// Shared CCI-P channel 0 types and reorder-buffer defaults for the AVMM/CCI-P bridge.
package ccip_avmm_pkg;

  localparam int CCIP_AVMM_ROB_DEPTH   = 64;
  localparam int CCIP_AVMM_ROB_ALMFULL = 8;

  typedef logic [$clog2(CCIP_AVMM_ROB_DEPTH)-1:0] t_rob_idx;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef struct packed {
    logic [1:0]   vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    logic [1:0]   vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    logic [15:0]  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic [511:0]       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  // Lines in a request: cl_len encodes 0/1/3 for 1/2/4 lines.
  function automatic logic [2:0] cl_lines(t_ccip_clLen len);
    return {1'b0, len} + 3'd1;
  endfunction

endpackage

// File: rtl/avmm_ccip_rob_ram.sv
// Reorder-buffer line storage: one write port, one read port with a registered 1-cycle read.
module avmm_ccip_rob_ram #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/avmm_ccip_rd_rob.sv
// CCI-P channel 0 read reorder buffer: retags requests with slot indices, returns lines in request order.
// Optional protocol checking compiled in with `define AVMM_CCIP_ROB_CHECK_EN.
module avmm_ccip_rd_rob
  import ccip_avmm_pkg::*;
#(
  parameter int DEPTH         = CCIP_AVMM_ROB_DEPTH,
  parameter int ALMFULL_SLOTS = CCIP_AVMM_ROB_ALMFULL
) (
  input  logic           clk,
  input  logic           reset_n,
  input  t_if_ccip_c0_Tx up_c0tx,
  output logic           up_c0TxAlmFull,
  output t_if_ccip_c0_Tx c0tx,
  input  logic           c0TxAlmFull,
  input  t_if_ccip_c0_Rx c0rx,
  output logic [511:0]   avmm_readdata,
  output logic           avmm_readdatavalid,
  output logic           rob_error
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] ALM_L   = (IDX_W+1)'(ALMFULL_SLOTS);

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]   used_q, used_d, free_slots;
  logic [DEPTH-1:0] slot_vld_q, slot_vld_d;
  logic [2:0]       alloc_n;
  logic             alloc, rsp_wr, drain;
  logic [IDX_W-1:0] rsp_slot;
  logic [511:0]     ram_rdata;
  logic             rd_vld_p1_q, rd_vld_p2_q;
  logic [511:0]     rd_data_p2_q;
  logic             unused_rx;

  // Request path: only the low mdata bits are replaced by the slot index.
  always_comb begin
    c0tx                        = up_c0tx;
    c0tx.hdr.mdata[IDX_W-1:0]   = tail_q;
    c0tx.valid                  = up_c0tx.valid & reset_n;
  end

  assign alloc      = up_c0tx.valid;
  assign alloc_n    = cl_lines(up_c0tx.hdr.cl_len);
  assign rsp_wr     = c0rx.rspValid && (c0rx.hdr.resp_type == eRSP_RDLINE);
  assign rsp_slot   = c0rx.hdr.mdata[IDX_W-1:0] + IDX_W'(c0rx.hdr.cl_num);
  assign drain      = slot_vld_q[head_q];
  assign free_slots = DEPTH_L - used_q;

  assign up_c0TxAlmFull = c0TxAlmFull | (free_slots < ALM_L) | ~reset_n;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    used_d     = used_q;
    slot_vld_d = slot_vld_q;
    if (alloc) begin
      tail_d = tail_q + IDX_W'(alloc_n);
      used_d = used_q + (IDX_W+1)'(alloc_n);
    end
    if (drain) begin
      head_d             = head_q + IDX_W'(1);
      used_d             = used_d - (IDX_W+1)'(1);
      slot_vld_d[head_q] = 1'b0;
    end
    // A response never targets the slot being drained: drain needs valid already set.
    if (rsp_wr) slot_vld_d[rsp_slot] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      used_q      <= '0;
      slot_vld_q  <= '0;
      rd_vld_p1_q <= 1'b0;
      rd_vld_p2_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      used_q      <= used_d;
      slot_vld_q  <= slot_vld_d;
      rd_vld_p1_q <= drain;
      rd_vld_p2_q <= rd_vld_p1_q;
    end
  end

  // p1 -> p2: RAM read data lands in the output register.
  always_ff @(posedge clk) begin
    if (!reset_n)         rd_data_p2_q <= '0;
    else if (rd_vld_p1_q) rd_data_p2_q <= ram_rdata;
  end

  avmm_ccip_rob_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (512)
  ) u_ram (
    .clk   (clk),
    .we    (rsp_wr),
    .waddr (rsp_slot),
    .wdata (c0rx.data),
    .re    (drain),
    .raddr (head_q),
    .rdata (ram_rdata)
  );

  assign avmm_readdata      = rd_data_p2_q;
  assign avmm_readdatavalid = rd_vld_p2_q;

`ifdef AVMM_CCIP_ROB_CHECK_EN
  logic             err_q, err_d;
  logic [IDX_W-1:0] rsp_off;

  // In-flight slots are the used_q entries starting at head, which also covers the full case.
  always_comb begin
    rsp_off = rsp_slot - head_q;
    err_d   = err_q;
    if (rsp_wr && (slot_vld_q[rsp_slot] || ({1'b0, rsp_off} >= used_q))) err_d = 1'b1;
    if (alloc && (free_slots < (IDX_W+1)'(alloc_n)))                   err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign rob_error = err_q;
`else
  assign rob_error = 1'b0;
`endif

  assign unused_rx = ^{c0rx.hdr, c0rx.mmioRdValid, c0rx.mmioWrValid};

endmodule

// File: tb/tb_avmm_ccip_rd_rob.sv
// Directed self-checking bench for avmm_ccip_rd_rob (DEPTH=64, ALMFULL_SLOTS=8).
module tb_avmm_ccip_rd_rob;
  import ccip_avmm_pkg::*;

`ifdef AVMM_CCIP_ROB_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset_n;
  t_if_ccip_c0_Tx up_c0tx;
  logic           up_c0TxAlmFull;
  t_if_ccip_c0_Tx c0tx;
  logic           c0TxAlmFull;
  t_if_ccip_c0_Rx c0rx;
  logic [511:0]   avmm_readdata;
  logic           avmm_readdatavalid;
  logic           rob_error;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [511:0] got_q [$];
  int           stamp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (avmm_readdatavalid) begin
    got_q.push_back(avmm_readdata);
    stamp_q.push_back(cyc);
  end

  avmm_ccip_rd_rob dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .up_c0tx            (up_c0tx),
    .up_c0TxAlmFull     (up_c0TxAlmFull),
    .c0tx               (c0tx),
    .c0TxAlmFull        (c0TxAlmFull),
    .c0rx               (c0rx),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid),
    .rob_error          (rob_error)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] line_of(input int tag);
    logic [31:0] w;
    w = 32'h5A5A_0000 ^ 32'(tag);
    return {16{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input t_ccip_clLen len, input t_rob_idx idx);
    t_ccip_c0_ReqMemHdr exp;
    up_c0tx.valid        = 1'b1;
    up_c0tx.hdr.cl_len   = len;
    up_c0tx.hdr.req_type = eREQ_RDLINE_I;
    up_c0tx.hdr.address  = 42'h1000 + 42'(idx);
    up_c0tx.hdr.mdata    = 16'hABFF;
    #1;
    exp = up_c0tx.hdr;
    exp.mdata = {10'h2AF, idx};
    check("req_hdr", c0tx.hdr, exp);
    tick();
    up_c0tx.valid = 1'b0;
  endtask

  task automatic set_rsp(input int base, input logic [1:0] cl, input int tag, input t_ccip_c0_rsp typ);
    c0rx.rspValid      = 1'b1;
    c0rx.hdr.resp_type = typ;
    c0rx.hdr.mdata     = 16'hABC0 | 16'(base);
    c0rx.hdr.cl_num    = cl;
    c0rx.data          = line_of(tag);
  endtask

  task automatic send_rsp(input int base, input logic [1:0] cl, input int tag);
    set_rsp(base, cl, tag, eRSP_RDLINE);
    tick();
    c0rx.rspValid = 1'b0;
  endtask

  initial begin
    up_c0tx     = '0;
    c0rx        = '0;
    c0TxAlmFull = 1'b0;
    reset_n     = 1'b0;
    up_c0tx.valid = 1'b1;
    tick();
    tick();
    check("rst_almfull", up_c0TxAlmFull, 1);
    check("rst_rdv", avmm_readdatavalid, 0);
    check("rst_rdata", avmm_readdata, 0);
    check("rst_err", rob_error, 0);
    check("rst_c0tx_valid", c0tx.valid, 0);
    reset_n = 1'b1;
    up_c0tx = '0;
    #1;
    check("idle_almfull", up_c0TxAlmFull, 0);
    c0TxAlmFull = 1'b1;
    #1;
    check("ccip_almfull_pass", up_c0TxAlmFull, 1);
    c0TxAlmFull = 1'b0;

    // Three single-line reads, responses return 2,0,1.
    up_c0tx.valid = 1'b1;
    #1;
    check("c0tx_valid", c0tx.valid, 1);
    send_req(eCL_LEN_1, 6'd0);
    send_req(eCL_LEN_1, 6'd1);
    send_req(eCL_LEN_1, 6'd2);
    send_rsp(2, 2'd0, 2);
    check("hol_block", avmm_readdatavalid, 0);
    send_rsp(0, 2'd0, 0);
    check("lat_n", avmm_readdatavalid, 0);
    tick();
    check("lat_n1", avmm_readdatavalid, 0);
    tick();
    check("lat_n2_vld", avmm_readdatavalid, 1);
    check("lat_n2_data", avmm_readdata, line_of(0));
    send_rsp(1, 2'd0, 1);
    check("hol_wait", avmm_readdatavalid, 0);
    tick();
    check("slot1_lat", avmm_readdatavalid, 0);
    tick();
    check("slot1_vld", avmm_readdatavalid, 1);
    check("slot1_data", avmm_readdata, line_of(1));
    tick();
    check("slot2_vld", avmm_readdatavalid, 1);
    check("slot2_data", avmm_readdata, line_of(2));
    tick();
    check("order_done", avmm_readdatavalid, 0);
    got_q.delete();

    // Fill toward the almost-full threshold with no responses (head = tail = 3).
    for (int i = 0; i < 7; i++) begin
      send_req(eCL_LEN_1, t_rob_idx'(3 + i));
      check("almfull_single", up_c0TxAlmFull, 0);
    end
    for (int b = 0; b < 11; b++) send_req(eCL_LEN_4, t_rob_idx'(10 + 4 * b));
    set_rsp(3, 2'd0, 103, eRSP_RDLINE);
    send_req(eCL_LEN_4, 6'd54);
    c0rx.rspValid = 1'b0;
    check("almfull_free9", up_c0TxAlmFull, 0);
    send_req(eCL_LEN_2, 6'd58);
    check("alloc_drain_used", up_c0TxAlmFull, 0);
    send_req(eCL_LEN_1, 6'd60);
    check("almfull_free7", up_c0TxAlmFull, 1);

    for (int s = 60; s >= 4; s--) send_rsp(s, 2'd0, 100 + s);
    repeat (64) tick();
    check("drain_count", got_q.size(), 58);
    for (int k = 0; k < 58; k++) check("drain_order", got_q[k], line_of(103 + k));
    check("drain_almfull", up_c0TxAlmFull, 0);
    check("drain_err", rob_error, 0);
    got_q.delete();
    stamp_q.delete();

    // 4-line burst straddling the wrap (tail 61 -> single, then 62).
    send_req(eCL_LEN_1, 6'd61);
    send_rsp(61, 2'd0, 261);
    send_req(eCL_LEN_4, 6'd62);
    send_rsp(62, 2'd3, 303);
    send_rsp(62, 2'd1, 301);
    send_rsp(62, 2'd0, 300);
    send_rsp(62, 2'd2, 302);
    repeat (6) tick();
    check("wrap_count", got_q.size(), 5);
    check("wrap_single", got_q[0], line_of(261));
    for (int k = 0; k < 4; k++) check("wrap_beat", got_q[k + 1], line_of(300 + k));
    check("wrap_consec", stamp_q[4] - stamp_q[1], 3);
    got_q.delete();

    // Non-RDLINE response and MMIO traffic must not write a slot (tail = 2).
    send_req(eCL_LEN_1, 6'd2);
    set_rsp(2, 2'd0, 500, eRSP_UMSG);
    tick();
    c0rx.rspValid    = 1'b0;
    c0rx.mmioRdValid = 1'b1;
    tick();
    c0rx.mmioRdValid = 1'b0;
    c0rx.mmioWrValid = 1'b1;
    tick();
    c0rx.mmioWrValid = 1'b0;
    repeat (4) tick();
    check("ignore_nonrd", got_q.size(), 0);
    check("ignore_err", rob_error, 0);
    send_rsp(2, 2'd0, 501);
    repeat (4) tick();
    check("after_ignore_cnt", got_q.size(), 1);
    check("after_ignore_data", got_q[0], line_of(501));

    // Duplicate response to slot 5 (head stays blocked on slot 3).
    send_req(eCL_LEN_1, 6'd3);
    send_req(eCL_LEN_1, 6'd4);
    send_req(eCL_LEN_1, 6'd5);
    send_rsp(5, 2'd0, 605);
    check("dup_first", rob_error, 0);
    send_rsp(5, 2'd0, 606);
    check("dup_err", rob_error, CHK);
    repeat (3) tick();
    check("dup_sticky", rob_error, CHK);
    reset_n = 1'b0;
    tick();
    check("rst2_err", rob_error, 0);
    check("rst2_almfull", up_c0TxAlmFull, 1);
    check("rst2_rdv", avmm_readdatavalid, 0);
    reset_n = 1'b1;
    tick();
    check("rst2_free", up_c0TxAlmFull, 0);
    send_rsp(9, 2'd0, 900);
    check("oor_err", rob_error, CHK);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    send_req(eCL_LEN_1, 6'd0);
    check("rst3_err", rob_error, 0);
    repeat (4) tick();
    check("rst3_no_stale", avmm_readdatavalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
